// File: rtl/joypad_scanner.sv
// joypad_scanner
//   Samples eight bouncy pushbuttons, brings them into the clk domain and
//   debounces each one independently. The debounced levels feed the joypad
//   register block (active-low) and debug LEDs (active-high). A one-cycle
//   interrupt request is raised whenever any button becomes pressed.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles before a button's
//                     debounced state flips (1..65535)
//   CNT_W           : per-button counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-low
//   btn_raw  : raw buttons, active-high, bit order
//              [7:0] = start, select, b, a, down, up, left, right
//   je       : debounced levels, active-low (0 = pressed)
//   irq_req  : one-cycle pulse after any release-to-press transition
//   pressed  : debounced levels, active-high (always ~je)

module joypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_raw,
  output logic [7:0] je,
  output logic       irq_req,
  output logic [7:0] pressed
);

  // The count value on which a still-disagreeing button finally flips.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       btn_meta;
  logic [7:0]       btn_sync;
  logic [7:0]       stable;
  logic [7:0]       stable_next;
  logic [CNT_W-1:0] cnt      [8];
  logic [CNT_W-1:0] cnt_next [8];

  // Two-flop synchronizer per button. Only btn_sync is used downstream;
  // btn_meta is allowed to go metastable and must not fan out anywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Next-state logic for every button's debounce counter. Agreement with the
  // debounced state clears the counter, so any single quiet cycle restarts
  // the count. Disagreement counts up until CNT_MAX, and on that edge the
  // state flips and the counter goes back to zero, so it can never wrap.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < 8; i++) begin
      cnt_next[i] = '0;
      if (btn_sync[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_next[i] = btn_sync[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state, counters and the interrupt request. The request is
  // computed from the edge's own 0-to-1 transitions, so several buttons
  // pressing together give one pulse, and releases never contribute.
  // Reset clears irq_req and stable together, so leaving reset cannot
  // itself look like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable  <= '0;
      irq_req <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable  <= stable_next;
      irq_req <= |(stable_next & ~stable);
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Both level outputs come straight off the stable register.
  assign pressed = stable;
  assign je      = ~stable;

endmodule
